// File: rtl/dds_phase_gen.sv
// Phase-accumulator front end for the sine lookup: emits a stream of ROM
// addresses with a per-sample enable, either continuously or for a burst.
module dds_phase_gen #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [ACC_W-1:0]  i_fcw,
  input  logic [ADDR_W-1:0] i_phase_ofs,
  input  logic [CNT_W-1:0]  i_burst_len,
  output logic              o_en,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state
);

  // Handshake: i_start is a level sampled at each edge and only takes effect
  // in IDLE with i_stop low; o_en qualifies o_addr for exactly one cycle per
  // sample, and there is no back-pressure from the lookup stage.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   fcw_q, fcw_d;
  logic [ADDR_W-1:0]  ofs_q, ofs_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               en_d, busy_d, done_d;
  logic [ADDR_W-1:0]  addr_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fcw_q  <= '0;
      ofs_q  <= '0;
      len_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      o_en   <= 1'b0;
      o_addr <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      fcw_q  <= fcw_d;
      ofs_q  <= ofs_d;
      len_q  <= len_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      o_en   <= en_d;
      o_addr <= addr_d;
      o_busy <= busy_d;
      o_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcw_d   = fcw_q;
    ofs_d   = ofs_q;
    len_d   = len_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    addr_d  = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          fcw_d   = i_fcw;
          ofs_d   = i_phase_ofs;
          len_d   = i_burst_len;
          // Sample 0 sits at phase 0, so the accumulator already holds sample 1.
          acc_d   = i_fcw;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          en_d    = 1'b1;
          addr_d  = i_phase_ofs;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_stop) begin
          state_d = S_IDLE;
        end else if ((len_q != '0) && (cnt_q == len_q)) begin
          busy_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          en_d   = 1'b1;
          busy_d = 1'b1;
          addr_d = acc_q[ACC_W-1 -: ADDR_W] + ofs_q;
          acc_d  = acc_q + fcw_q;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: a vector table of per-edge inputs and
// hand-computed outputs, plus looped sequences for wrap and mid-burst reset.
module tb_dds_phase_gen;

  localparam int ACC_W  = 32;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop;
  logic [ACC_W-1:0]  fcw;
  logic [ADDR_W-1:0] ofs;
  logic [CNT_W-1:0]  len;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  int total;
  int bad;

  typedef struct {
    logic              rst_n;
    logic              start;
    logic              stop;
    logic [ACC_W-1:0]  fcw;
    logic [ADDR_W-1:0] ofs;
    logic [CNT_W-1:0]  len;
    logic              exp_en;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_busy;
    logic              exp_done;
  } vec_t;

  vec_t vecs[$];

  dds_phase_gen #(
    .ACC_W (ACC_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_fcw      (fcw),
    .i_phase_ofs(ofs),
    .i_burst_len(len),
    .o_en       (en),
    .o_addr     (addr),
    .o_busy     (busy),
    .o_done     (done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h want 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int idx, input logic e_en,
                            input logic [ADDR_W-1:0] e_addr, input logic e_busy,
                            input logic e_done);
    check({tag, ".en"},   idx, 32'(en),   32'(e_en));
    check({tag, ".addr"}, idx, 32'(addr), 32'(e_addr));
    check({tag, ".busy"}, idx, 32'(busy), 32'(e_busy));
    check({tag, ".done"}, idx, 32'(done), 32'(e_done));
  endtask

  task automatic add(input logic r, input logic s, input logic p, input logic [ACC_W-1:0] f,
                     input logic [ADDR_W-1:0] o, input logic [CNT_W-1:0] l,
                     input logic e_en, input logic [ADDR_W-1:0] e_addr,
                     input logic e_busy, input logic e_done);
    vec_t v;
    v.rst_n = r; v.start = s; v.stop = p; v.fcw = f; v.ofs = o; v.len = l;
    v.exp_en = e_en; v.exp_addr = e_addr; v.exp_busy = e_busy; v.exp_done = e_done;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic p,
                       input logic [ACC_W-1:0] f, input logic [ADDR_W-1:0] o,
                       input logic [CNT_W-1:0] l);
    rst_n = r; start = s; stop = p; fcw = f; ofs = o; len = l;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 1'b1, 1'b0, 32'h0040_0000, 10'h000, 16'd5);

    //   rst start stop fcw           ofs     len    en addr    busy done
    // reset held with start asserted
    add(0, 1, 0, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 0, 0);
    add(0, 1, 0, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 0, 0);
    add(0, 1, 0, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 0, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 0, 0);
    // burst of 5, step 1; input changes during RUN are ignored
    add(1, 1, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h000, 1, 0);
    add(1, 0, 0, 32'h0800_0000, 10'h123, 16'd2,  1, 10'h001, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h002, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h003, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h004, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 1, 1);
    // start at the DONE->IDLE edge is ignored, the next one is taken (len=1)
    add(1, 1, 0, 32'h0040_0000, 10'h000, 16'd1,  0, 10'h000, 0, 0);
    add(1, 1, 0, 32'h0040_0000, 10'h000, 16'd1,  1, 10'h000, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd1,  0, 10'h000, 1, 1);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd1,  0, 10'h000, 0, 0);
    // start and stop together in IDLE: no start
    add(1, 1, 1, 32'h0040_0000, 10'h000, 16'd3,  0, 10'h000, 0, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd3,  0, 10'h000, 0, 0);
    // offset wrap, step 4; new fcw with start mid-RUN leaves the step alone
    add(1, 1, 0, 32'h0100_0000, 10'h3FE, 16'd0,  1, 10'h3FE, 1, 0);
    add(1, 0, 0, 32'h0100_0000, 10'h3FE, 16'd0,  1, 10'h002, 1, 0);
    add(1, 0, 0, 32'h0100_0000, 10'h3FE, 16'd0,  1, 10'h006, 1, 0);
    add(1, 1, 0, 32'h0080_0000, 10'h000, 16'd0,  1, 10'h00A, 1, 0);
    add(1, 0, 0, 32'h0080_0000, 10'h000, 16'd0,  1, 10'h00E, 1, 0);
    add(1, 0, 1, 32'h0080_0000, 10'h000, 16'd0,  0, 10'h000, 0, 0);
    add(1, 0, 0, 32'h0080_0000, 10'h000, 16'd0,  0, 10'h000, 0, 0);
    // stop at the third RUN edge of a 5-sample burst
    add(1, 1, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h000, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h001, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  1, 10'h002, 1, 0);
    add(1, 0, 1, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 0, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h000, 16'd5,  0, 10'h000, 0, 0);
    // stop coinciding with the final count: stop wins, no done
    add(1, 1, 0, 32'h0040_0000, 10'h010, 16'd2,  1, 10'h010, 1, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h010, 16'd2,  1, 10'h011, 1, 0);
    add(1, 0, 1, 32'h0040_0000, 10'h010, 16'd2,  0, 10'h000, 0, 0);
    add(1, 0, 0, 32'h0040_0000, 10'h010, 16'd2,  0, 10'h000, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].start, vecs[i].stop, vecs[i].fcw, vecs[i].ofs, vecs[i].len);
      step();
      check_outs("vec", i, vecs[i].exp_en, vecs[i].exp_addr, vecs[i].exp_busy, vecs[i].exp_done);
    end
    check("idle_state", 0, 32'(dbg_state), 32'd0);

    // continuous mode: step of 4 wraps back to 0 after 256 samples
    for (int n = 0; n < 260; n++) begin
      drive(1'b1, (n == 0), 1'b0, 32'h0100_0000, 10'h000, 16'd0);
      step();
      check_outs("cont", n, 1'b1, ADDR_W'((n * 4) % 1024), 1'b1, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0100_0000, 10'h000, 16'd0);
    step();
    check_outs("cont_stop", 0, 1'b0, 10'h000, 1'b0, 1'b0);

    // reset after sample 4 of a 10-sample burst
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, (n == 0), 1'b0, 32'h0040_0000, 10'h000, 16'd10);
      step();
      check_outs("mid", n, 1'b1, ADDR_W'(n), 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0040_0000, 10'h000, 16'd10);
    step();
    check_outs("mid_rst", 0, 1'b0, 10'h000, 1'b0, 1'b0);
    for (int n = 0; n < 8; n++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0040_0000, 10'h000, 16'd10);
      step();
      check_outs("post_rst", n, 1'b0, 10'h000, 1'b0, 1'b0);
    end
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, (n == 0), 1'b0, 32'h0040_0000, 10'h000, 16'd10);
      step();
      check_outs("fresh", n, 1'b1, ADDR_W'(n), 1'b1, 1'b0);
    end
    check("run_state", 0, 32'(dbg_state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
